// File: rtl/noc_merge_pkg.sv
// noc_merge_pkg: shared types and helpers for the 2:1 NoC flit merge.
//   merge_state_e : packet-level lock state of the merge
//   FLIT_W        : native NoC flit width
//   is_tail()     : tail flag of a native-width flit
package noc_merge_pkg;

  localparam int FLIT_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } merge_state_e;

  function automatic logic is_tail(input logic [FLIT_W-1:0] flit);
    return flit[FLIT_W-1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter with packet lock.
//   req[1:0] : request per input (input valid)
//   ptr      : input preferred when both request
//   lock     : a packet is in progress; grant is pinned to lock_id
//   lock_id  : input that owns the packet in progress
//   gnt[1:0] : one-hot (or zero) grant
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       lock,
  input  logic       lock_id,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (lock) begin
      // Pinned even when the owner has no flit, so packets never interleave.
      gnt = lock_id ? 2'b10 : 2'b01;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/merge2_sync.sv
// merge2_sync: clocked 2:1 packet merge with round-robin packet arbitration.
//   CLK, _RESET          : clock, asynchronous active-low reset
//   in0_* / in1_*        : valid/ready flit inputs from the two sources
//   out_data, out_sel    : registered merged flit and its source index
//   out_valid, out_ready : output handshake
// A packet that wins the output keeps it until its tail flit is accepted.
//
// state | meaning
// IDLE  | no packet in progress, arbitrate per rr_ptr
// LOCK0 | packet from in0 in progress, only in0 may transfer
// LOCK1 | packet from in1 in progress, only in1 may transfer
module merge2_sync
  import noc_merge_pkg::*;
#(
  parameter int W        = FLIT_W,
  parameter int TAIL_BIT = W - 1,
  parameter bit RR_INIT  = 1'b0
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic [W-1:0] out_data,
  output logic         out_sel,
  output logic         out_valid,
  input  logic         out_ready
);

  merge_state_e state_q, state_d;
  logic         rr_ptr_q, rr_ptr_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         out_sel_q, out_sel_d;

  logic [1:0]   gnt;
  logic         space;
  logic         xfer0, xfer1, xfer, xfer_id, xfer_tail;
  logic [W-1:0] xfer_data;

  rr_arb2 u_arb (
    .req     ({in1_valid, in0_valid}),
    .ptr     (rr_ptr_q),
    .lock    (state_q != IDLE),
    .lock_id (state_q == LOCK1),
    .gnt     (gnt)
  );

  // Output register can take a flit when empty or draining this cycle.
  assign space = !out_valid_q || out_ready;

  // Gating with _RESET keeps both readies low for the whole reset pulse,
  // not just after the first edge.
  assign in0_ready = gnt[0] && space && _RESET;
  assign in1_ready = gnt[1] && space && _RESET;

  assign xfer0     = in0_valid && in0_ready;
  assign xfer1     = in1_valid && in1_ready;
  assign xfer      = xfer0 || xfer1;
  assign xfer_id   = xfer1;
  assign xfer_data = xfer1 ? in1_data : in0_data;
  assign xfer_tail = xfer_data[TAIL_BIT];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = xfer_data;
      out_sel_d   = xfer_id;
      if (xfer_tail) begin
        state_d  = IDLE;
        rr_ptr_d = ~xfer_id;
      end else begin
        state_d = xfer_id ? LOCK1 : LOCK0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q     <= IDLE;
      rr_ptr_q    <= RR_INIT;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_merge2_sync.sv
// tb_merge2_sync: directed scenarios plus a randomized run against a
// packet-level reference model of the 2:1 merge.
module tb_merge2_sync;

  logic       CLK;
  logic       _RESET;
  logic [8:0] in0_data, in1_data, out_data;
  logic       in0_valid, in1_valid, in0_ready, in1_ready;
  logic       out_sel, out_valid, out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  merge2_sync #(.W(9), .TAIL_BIT(8), .RR_INIT(1'b0)) dut (
    .CLK       (CLK),
    ._RESET    (_RESET),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    _RESET = 1'b0;
    in0_valid = 1'b1; in0_data = 9'h1AA;
    in1_valid = 1'b1; in1_data = 9'h1BB;
    out_ready = 1'b1;
    #2;
    n_checks++;
    if ({out_valid, out_sel, out_data} !== 11'd0) begin
      n_fail++; $display("FAIL reset_out got %b/%b/%h want 0/0/000", out_valid, out_sel, out_data);
    end
    @(posedge CLK); #1;
    n_checks++;
    if ({in1_ready, in0_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready got %b want 00", {in1_ready, in0_ready});
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(negedge CLK);
    _RESET = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_alternation();
    in0_data = 9'h1A0; in1_data = 9'h1B0;
    in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if ({in1_ready, in0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL alt_ready[%0d] got %b", i, {in1_ready, in0_ready});
      end
      tick();
      n_checks++;
      if ({out_valid, out_sel, out_data} !== ((i % 2 == 0) ? {2'b10, 9'h1A0} : {2'b11, 9'h1B0})) begin
        n_fail++; $display("FAIL alt_out[%0d] got %b/%b/%h", i, out_valid, out_sel, out_data);
      end
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL alt_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_packet_lock();
    // Single in0 tail first so in1 holds round-robin priority during the packet.
    in0_valid = 1'b1; in0_data = 9'h1AB; in1_valid = 1'b0;
    tick();
    in0_data = 9'h001;
    tick();
    n_checks++;
    if ({out_valid, out_sel, out_data} !== {2'b10, 9'h001}) begin
      n_fail++; $display("FAIL lock_first got %b/%b/%h want 1/0/001", out_valid, out_sel, out_data);
    end
    in1_valid = 1'b1; in1_data = 9'h1FF;
    in0_data = 9'h002;
    #1;
    n_checks++;
    if ({in1_ready, in0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL lock_ready_mid got %b want 01", {in1_ready, in0_ready});
    end
    tick();
    in0_data = 9'h103;
    #1;
    n_checks++;
    if ({in1_ready, in0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL lock_ready_tail got %b want 01", {in1_ready, in0_ready});
    end
    tick();
    n_checks++;
    if ({out_valid, out_sel, out_data} !== {2'b10, 9'h103}) begin
      n_fail++; $display("FAIL lock_tail got %b/%b/%h want 1/0/103", out_valid, out_sel, out_data);
    end
    in0_valid = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, out_sel, out_data} !== {2'b11, 9'h1FF}) begin
      n_fail++; $display("FAIL lock_after got %b/%b/%h want 1/1/1FF", out_valid, out_sel, out_data);
    end
    in1_valid = 1'b0;
    tick();
  endtask

  task automatic test_locked_bubble();
    in0_valid = 1'b1; in0_data = 9'h004;
    in1_valid = 1'b1; in1_data = 9'h1CC;
    tick();
    n_checks++;
    if ({out_valid, out_sel, out_data} !== {2'b10, 9'h004}) begin
      n_fail++; $display("FAIL bubble_first got %b/%b/%h want 1/0/004", out_valid, out_sel, out_data);
    end
    in0_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({in1_ready, in0_ready} !== 2'b01) begin
        n_fail++; $display("FAIL bubble_ready[%0d] got %b want 01", i, {in1_ready, in0_ready});
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL bubble_idle[%0d] got %b want 0", i, out_valid);
      end
    end
    in0_valid = 1'b1; in0_data = 9'h105;
    tick();
    n_checks++;
    if ({out_valid, out_sel, out_data} !== {2'b10, 9'h105}) begin
      n_fail++; $display("FAIL bubble_tail got %b/%b/%h want 1/0/105", out_valid, out_sel, out_data);
    end
    in0_valid = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, out_sel, out_data} !== {2'b11, 9'h1CC}) begin
      n_fail++; $display("FAIL bubble_in1 got %b/%b/%h want 1/1/1CC", out_valid, out_sel, out_data);
    end
    in1_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    in0_valid = 1'b1; in0_data = 9'h1A1;
    in1_valid = 1'b1; in1_data = 9'h1B1;
    out_ready = 1'b1;
    tick();
    in0_data = 9'h1A2;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({out_valid, out_sel, out_data, in1_ready, in0_ready} !== {2'b10, 9'h1A1, 2'b00}) begin
        n_fail++; $display("FAIL bp_hold[%0d] got %b/%b/%h rdy %b want 1/0/1A1 rdy 00",
                           i, out_valid, out_sel, out_data, {in1_ready, in0_ready});
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if ({in1_ready, in0_ready} !== 2'b10) begin
      n_fail++; $display("FAIL bp_release_ready got %b want 10", {in1_ready, in0_ready});
    end
    tick();
    n_checks++;
    if ({out_valid, out_sel, out_data} !== {2'b11, 9'h1B1}) begin
      n_fail++; $display("FAIL bp_release got %b/%b/%h want 1/1/1B1", out_valid, out_sel, out_data);
    end
    in1_valid = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, out_sel, out_data} !== {2'b10, 9'h1A2}) begin
      n_fail++; $display("FAIL bp_next got %b/%b/%h want 1/0/1A2", out_valid, out_sel, out_data);
    end
    in0_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_requester();
    in0_valid = 1'b0; in1_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in1_data = 9'h1D0 + 9'(i);
      #1;
      n_checks++;
      if ({in1_ready, in0_ready} !== 2'b10) begin
        n_fail++; $display("FAIL single_ready[%0d] got %b want 10", i, {in1_ready, in0_ready});
      end
      tick();
      n_checks++;
      if ({out_valid, out_sel, out_data} !== {2'b11, 9'h1D0 + 9'(i)}) begin
        n_fail++; $display("FAIL single_out[%0d] got %b/%b/%h", i, out_valid, out_sel, out_data);
      end
    end
    in1_valid = 1'b0;
    tick();
  endtask

  task automatic test_mid_packet_reset();
    in0_valid = 1'b1; in0_data = 9'h012; in1_valid = 1'b0;
    tick();
    in0_valid = 1'b0;
    _RESET = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in1_ready, in0_ready} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_async got valid %b rdy %b want 0 00", out_valid, {in1_ready, in0_ready});
    end
    @(negedge CLK);
    @(negedge CLK);
    _RESET = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_release got %b want 0", out_valid);
    end
    in1_valid = 1'b1; in1_data = 9'h155;
    #1;
    n_checks++;
    if ({in1_ready, in0_ready} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_ready got %b want 10", {in1_ready, in0_ready});
    end
    tick();
    n_checks++;
    if ({out_valid, out_sel, out_data} !== {2'b11, 9'h155}) begin
      n_fail++; $display("FAIL midrst_out got %b/%b/%h want 1/1/155", out_valid, out_sel, out_data);
    end
    in1_valid = 1'b0;
    tick();
  endtask

  // Randomized traffic. The model tracks the output register contents, which
  // source (if any) owns the output for a packet, and who goes first next.
  task automatic test_random();
    logic       m_valid;
    logic [8:0] m_data;
    logic       m_sel;
    int         owner, prio, g, x;
    logic       sp;
    logic [1:0] exp_rdy;
    logic [1:0] p_valid;
    logic [8:0] p_data [2];
    int         p_left [2];

    _RESET = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
    @(negedge CLK);
    _RESET = 1'b1;
    tick();
    m_valid = 1'b0; m_data = '0; m_sel = 1'b0; owner = -1; prio = 0;
    for (int k = 0; k < 2; k++) begin
      p_left[k] = int'($urandom_range(1, 3));
      p_data[k] = {p_left[k] == 1, 8'($urandom)};
    end
    p_valid = 2'b00;

    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++)
        if (!p_valid[k] && $urandom_range(9) < 7) p_valid[k] = 1'b1;
      in0_valid = p_valid[0]; in0_data = p_data[0];
      in1_valid = p_valid[1]; in1_data = p_data[1];
      out_ready = ($urandom_range(9) < 7);
      #1;

      sp = !m_valid || out_ready;
      if (owner >= 0)                  g = owner;
      else if (p_valid == 2'b11)       g = prio;
      else if (p_valid[0])             g = 0;
      else if (p_valid[1])             g = 1;
      else                             g = -1;
      exp_rdy = 2'b00;
      if (g >= 0 && sp) exp_rdy[g] = 1'b1;

      n_checks++;
      if ({in1_ready, in0_ready} !== exp_rdy) begin
        n_fail++; $display("FAIL rnd_ready[%0d] got %b want %b", c, {in1_ready, in0_ready}, exp_rdy);
      end
      n_checks++;
      if (out_valid !== m_valid || (m_valid && {out_sel, out_data} !== {m_sel, m_data})) begin
        n_fail++; $display("FAIL rnd_out[%0d] got %b/%b/%h want %b/%b/%h",
                           c, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
      end

      x = (g >= 0 && sp && p_valid[g]) ? g : -1;
      if (x >= 0) begin
        m_valid = 1'b1;
        m_data  = p_data[x];
        m_sel   = x[0];
        if (p_data[x][8]) begin
          owner = -1;
          prio  = 1 - x;
        end else begin
          owner = x;
        end
        p_left[x]--;
        if (p_left[x] == 0) p_left[x] = int'($urandom_range(1, 3));
        p_data[x]  = {p_left[x] == 1, 8'($urandom)};
        p_valid[x] = ($urandom_range(3) != 0);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      tick();
    end
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  initial begin
    _RESET = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = '0; in1_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_alternation();
    test_packet_lock();
    test_locked_bubble();
    test_backpressure();
    test_single_requester();
    test_mid_packet_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
